pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core. Sits beside the ID stage and decodes the IF/ID instruction word with the same opcode set as the ID immediate generator.
- Tracks what occupies ID/EX in a shadow register.
- Drives all stall, bubble and flush enables for PC, IF/ID and ID/EX, arbitrating load-use, taken-branch and data-memory-wait conditions.
- Keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/id_reg_use_dec.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: opcodes, controller
// state encoding and ID register-use bundle.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_LUSTALL = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       mem_read;
  } id_use_t;

endpackage

// File: rtl/id_reg_use_dec.sv
// Register-use decode of the IF/ID word:
// which sources it reads, whether it writes rd.
module id_reg_use_dec
  import riscv_pkg::*;
(
  input  logic [31:0] id_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        mem_read
);

  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign rd  = id_instr[11:7];

  // opcode class -> register usage flags
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    mem_read  = 1'b0;
    unique case (id_instr[6:0])
      OP_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        mem_read  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch
// flush and dmem wait arbitration plus counters.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

  id_use_t     dec;
  ctrl_state_e state_q, state_d;
  logic [4:0]  ex_rd_q;
  logic        ex_memrd_q;
  logic [TW-1:0] wcnt_q;
  logic        memwait, do_br, do_lu, lu;

  id_reg_use_dec u_dec (
    .id_instr  (id_instr),
    .rs1       (dec.rs1),
    .rs2       (dec.rs2),
    .rd        (dec.rd),
    .uses_rs1  (dec.uses_rs1),
    .uses_rs2  (dec.uses_rs2),
    .writes_rd (dec.writes_rd),
    .mem_read  (dec.mem_read)
  );

  // While in reset the outputs show the
  // no-hazard RUN values regardless of inputs.
  assign lu = ex_memrd_q && (ex_rd_q != 5'd0) &&
              ((dec.uses_rs1 && dec.rs1 == ex_rd_q) ||
               (dec.uses_rs2 && dec.rs2 == ex_rd_q));

  assign memwait = rst_n && mem_req && !dmem_ready;
  assign do_br   = rst_n && !memwait && ex_branch_taken;
  assign do_lu   = !memwait && !do_br && lu;

  assign ctrl_state = state_q;

  // prioritised Mealy enables and next state
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    state_d      = ST_RUN;
    unique case (1'b1)
      memwait: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        ex_mem_write = 1'b0;
        state_d      = ST_WAIT;
      end
      do_br: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = ST_FLUSH;
      end
      do_lu: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        state_d      = ST_LUSTALL;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // shadow of the instruction entering EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q    <= 5'd0;
      ex_memrd_q <= 1'b0;
    end else if (memwait) begin
      ex_rd_q    <= ex_rd_q;
      ex_memrd_q <= ex_memrd_q;
    end else if (id_ex_bubble) begin
      ex_rd_q    <= 5'd0;
      ex_memrd_q <= 1'b0;
    end else begin
      ex_rd_q    <= dec.writes_rd ? dec.rd : 5'd0;
      ex_memrd_q <= dec.mem_read;
    end
  end

  // performance counters, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_br)     flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // consecutive wait length, saturating,
  // with a sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      mem_timeout <= 1'b0;
    end else if (memwait) begin
      if (wcnt_q != TMAX) wcnt_q <= wcnt_q + TW'(1);
      if (wcnt_q == TMAX - TW'(1)) mem_timeout <= 1'b1;
    end else begin
      wcnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl:
// table of single-cycle vectors plus corner sequences.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD   = 32'h00128333;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADD00 = 32'h00000333;
  localparam logic [31:0] I_LUI5  = 32'h000282B7;
  localparam logic [31:0] I_SW5   = 32'h00512023;
  localparam logic [31:0] I_ADDI  = 32'h00128393;
  localparam logic [31:0] I_NOP   = 32'h00000013;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write}
  localparam logic [4:0] E_RUN = 5'b11001;
  localparam logic [4:0] E_LU  = 5'b00011;
  localparam logic [4:0] E_BR  = 5'b11111;
  localparam logic [4:0] E_W   = 5'b00000;

  logic        clk, rst_n;
  logic [31:0] id_instr;
  logic        ex_branch_taken, mem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush;
  logic        id_ex_bubble, ex_mem_write;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic        mreq;
    logic        rdy;
    logic [4:0]  eo;
    logic [1:0]  st;
  } vec_t;

  vec_t tv[19];

  pipe_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_instr        (id_instr),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_write    (ex_mem_write),
    .ctrl_state      (ctrl_state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, if_id_flush,
            id_ex_bubble, ex_mem_write};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic b, input logic mr,
                       input logic rd);
    @(negedge clk);
    id_instr        = ins;
    ex_branch_taken = b;
    mem_req         = mr;
    dmem_ready      = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_instr = I_NOP;
    ex_branch_taken = 1'b0;
    mem_req = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tv[0]  = '{I_LW5,   0, 0, 1, E_RUN, 2'd0};
    tv[1]  = '{I_ADD,   0, 0, 1, E_LU,  2'd0};
    tv[2]  = '{I_ADD,   0, 0, 1, E_RUN, 2'd3};
    tv[3]  = '{I_LW0,   0, 0, 1, E_RUN, 2'd0};
    tv[4]  = '{I_ADD00, 0, 0, 1, E_RUN, 2'd0};
    tv[5]  = '{I_LW5,   0, 0, 1, E_RUN, 2'd0};
    tv[6]  = '{I_LUI5,  0, 0, 1, E_RUN, 2'd0};
    tv[7]  = '{I_LW5,   0, 0, 1, E_RUN, 2'd0};
    tv[8]  = '{I_SW5,   0, 0, 1, E_LU,  2'd0};
    tv[9]  = '{I_NOP,   0, 0, 1, E_RUN, 2'd3};
    tv[10] = '{I_LW5,   0, 0, 1, E_RUN, 2'd0};
    tv[11] = '{I_ADDI,  1, 0, 1, E_BR,  2'd0};
    tv[12] = '{I_NOP,   0, 0, 1, E_RUN, 2'd2};
    tv[13] = '{I_LW5,   0, 0, 1, E_RUN, 2'd0};
    tv[14] = '{I_ADDI,  0, 1, 1, E_LU,  2'd0};
    tv[15] = '{I_NOP,   0, 1, 0, E_W,   2'd3};
    tv[16] = '{I_NOP,   1, 1, 0, E_W,   2'd1};
    tv[17] = '{I_NOP,   1, 1, 1, E_BR,  2'd1};
    tv[18] = '{I_NOP,   0, 0, 1, E_RUN, 2'd2};

    rst_n = 1'b0;
    id_instr = I_NOP;
    ex_branch_taken = 1'b0;
    mem_req = 1'b0;
    dmem_ready = 1'b1;
    #12;
    chk("reset_outs", 32'(outs()), 32'(E_RUN));
    chk("reset_state", 32'(ctrl_state), 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_flush", flush_cnt, 32'd0);
    chk("reset_tmo", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].instr, tv[i].br, tv[i].mreq, tv[i].rdy);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tv[i].eo));
      chk($sformatf("vec%0d_state", i), 32'(ctrl_state), 32'(tv[i].st));
    end
    drive(I_NOP, 0, 0, 1);
    chk("tbl_stall", stall_cnt, 32'd5);
    chk("tbl_flush", flush_cnt, 32'd2);
    chk("tbl_tmo", 32'(mem_timeout), 32'd0);

    // branch beats load-use
    do_reset();
    drive(I_LW5, 0, 0, 1);
    drive(I_ADD, 1, 0, 1);
    chk("brlu_outs", 32'(outs()), 32'(E_BR));
    drive(I_NOP, 0, 0, 1);
    chk("brlu_state", 32'(ctrl_state), 32'd2);
    chk("brlu_flush", flush_cnt, 32'd1);
    chk("brlu_stall", stall_cnt, 32'd0);

    // branch held through a 3-cycle dmem wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(I_NOP, 1, 1, 0);
      chk($sformatf("wait%0d_outs", i), 32'(outs()), 32'(E_W));
    end
    drive(I_NOP, 1, 1, 1);
    chk("wait_br_outs", 32'(outs()), 32'(E_BR));
    chk("wait_br_state", 32'(ctrl_state), 32'd1);
    drive(I_NOP, 0, 0, 1);
    chk("wait_stall", stall_cnt, 32'd3);
    chk("wait_flush", flush_cnt, 32'd1);
    chk("wait_after", 32'(outs()), 32'(E_RUN));

    // timeout after 4 wait cycles, sticky
    do_reset();
    drive(I_NOP, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_pre", 32'(mem_timeout), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo_set", 32'(mem_timeout), 32'd1);
    chk("tmo_stall", stall_cnt, 32'd4);
    drive(I_NOP, 0, 1, 1);
    drive(I_NOP, 0, 0, 1);
    drive(I_NOP, 0, 0, 1);
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);

    // asynchronous reset in the middle of a wait
    drive(I_NOP, 0, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_wait_outs", 32'(outs()), 32'(E_W));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'(E_RUN));
    chk("mid_rst_state", 32'(ctrl_state), 32'd0);
    chk("mid_rst_stall", stall_cnt, 32'd0);
    chk("mid_rst_tmo", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_outs", 32'(outs()), 32'(E_W));
    @(posedge clk);
    #1;
    chk("post_rst_state", 32'(ctrl_state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
